adc_vip_top: RTL and testbench
==============================

Name: adc_vip_top

Overview:
- Single-clock capture harness: an ADC sample-source model feeds a synchronous AXI-Stream-style FIFO.
- The FIFO drains into a VIP capture RAM of SAMP words.
- vip_full flags completion so the bench can dump the RAM.
- FIFO status flags and counts are exported so the bench can verify the FIFO never underflows once streaming.

Parameters:
- PERIOD, 12: sawtooth period of the source model in samples (integer ≥2).
- SAMP, 256: number of samples the VIP captures.
- TDATA_WIDTH, 16: sample width in bits.
- FIFO_DEPTH, 32: FIFO depth; power of two, ≥16.
- PROG_EMPTY_THRESH, 16: prog_empty threshold (occupancy).
- PROG_FULL_THRESH, 16: prog_full threshold (occupancy).

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- adc_en  in  1  source enable, level-sensitive.
- vip_full  out  1  SAMP samples captured.
- almost_empty_axis  out  1  occupancy ≤ 1.
- almost_full_axis  out  1  occupancy ≥ FIFO_DEPTH-1.
- prog_empty_axis  out  1  occupancy ≤ PROG_EMPTY_THRESH.
- prog_full_axis  out  1  occupancy ≥ PROG_FULL_THRESH.
- rd_data_count_axis  out  $clog2(FIFO_DEPTH)  occupancy, saturating at all-ones.
- wr_data_count_axis  out  $clog2(FIFO_DEPTH)  occupancy, saturating at all-ones.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset (rst_n=0, asynchronous assert, synchronous release):
  - Source index n=0; FIFO emptied; capture pointer=0.
  - vip_full=0, almost_empty=1, prog_empty=1, almost_full=0, prog_full=0, counts=0.
  - RAM contents are not cleared.
- Source:
  - On each edge with adc_en=1 and FIFO not full, it writes sample (n mod PERIOD), zero-extended to TDATA_WIDTH, then n++.
  - FIFO full → stall: hold the sample, never drop it, n unchanged.
  - adc_en=0 → no write.
- FIFO:
  - First-word-fall-through; a word written at edge k is visible (not empty) after edge k and may be popped at edge k+1.
  - Simultaneous push and pop leaves occupancy unchanged.
  - Push when full, or pop when empty, is impossible by construction.
- All flags and counts are registered from post-edge occupancy.
- Capture:
  - On each edge with FIFO not empty and vip_full=0, pop the word into ram[ptr], then ptr++.
  - When ptr reaches SAMP, vip_full goes 1 on the same edge as the last write, and stays 1 until reset.
  - After vip_full, no pops occur; the FIFO fills and the source stalls.
- RAM:
  - Array named ram[0:SAMP-1], 32 bits wide, data zero-extended.
  - Lives in instance vip_inst, so hierarchical read DUT.vip_inst.ram[i] works.
- Timing with adc_en raised before edge 1 and held high:
  - Write at edge 1; ram[0] written at edge 2.
  - ram[i] = i mod PERIOD.
  - vip_full rises at edge SAMP+1.
  - Steady occupancy is 1 (almost_empty=1, prog_empty=1, never empty between pushes).
- adc_en drop mid-stream: capture pauses once the FIFO drains; it resumes seamlessly with no gaps in the n sequence.
- Reset mid-operation: everything restarts from n=0, ptr=0.

Decomposition:
- Shared package adc_vip_pkg:
  - localparams for counter width ($clog2(FIFO_DEPTH)) and RAM word width (32).
  - typedef for the sample word.
- One natural sub-module: adc_vip_capture, instantiated as vip_inst. It holds the ram array, the pointer and vip_full.
- Source and FIFO stay in the top.

Test Plan:
- Reset: rst_n=0 mid-stream → all outputs take their reset values immediately (asynchronous); after release, ram[0] is rewritten with 0.
- Basic capture: rst_n released, adc_en=1 held → vip_full=1 exactly at edge 257; ram[i]=i mod 12 for i=0..255 (ram[11]=11, ram[12]=0, ram[255]=3).
- Flags while streaming: with adc_en=1, occupancy stays ≤1 → almost_empty=1, prog_empty=1, counts ≤1, almost_full=0 throughout capture.
- Fill after done: keep adc_en=1 after vip_full:
  - after 32 more edges, occupancy is 32 and counts saturate at 31;
  - almost_full=1 and prog_full=1;
  - the source stalls and n stops advancing.
- Gap: adc_en=0 for 10 cycles mid-capture → FIFO drains to 0; after re-enable, the sequence continues without a skipped or duplicated value; vip_full is delayed by exactly 10 cycles.
- Threshold: PROG_FULL_THRESH=16 → prog_full rises on the edge where occupancy reaches 16; it is never set at occupancy 15.

Source files
------------

// File: rtl/adc_vip_pkg.sv
// Shared types and widths for the ADC capture harness.
// Imported by the top and by the capture sub-module.
package adc_vip_pkg;

  localparam int TDATA_W = 16;
  localparam int FIFO_D  = 32;
  localparam int RAM_W   = 32;

  function automatic int cnt_w(input int depth);
    return $clog2(depth);
  endfunction

  localparam int CNT_W = cnt_w(FIFO_D);

  typedef logic [TDATA_W-1:0] sample_t;

endpackage

// File: rtl/adc_vip_capture.sv
// VIP capture: pops FIFO words into ram[0:SAMP-1] until full.
// Ports: clk, rst_n, s_valid/s_data in, s_ready/vip_full out.
module adc_vip_capture
  import adc_vip_pkg::*;
#(
  parameter int SAMP = 256,
  parameter int DW   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          vip_full
);

  localparam int PTRW = $clog2(SAMP);

  logic [RAM_W-1:0] ram [0:SAMP-1];

  logic [PTRW-1:0] ptr_q, ptr_d;
  logic            full_q, full_d;
  logic            wr;

  assign s_ready  = ~full_q;
  assign vip_full = full_q;
  assign wr       = s_valid & ~full_q;

  always_comb begin
    ptr_d  = ptr_q;
    full_d = full_q;
    if (wr) begin
      ptr_d = ptr_q + 1'b1;
      // Last slot: flag goes high on the same edge as the write.
      if (ptr_q == PTRW'(SAMP - 1)) begin
        full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      full_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      full_q <= full_d;
    end
  end

  // Capture storage survives reset.
  always_ff @(posedge clk) begin
    if (wr) begin
      ram[ptr_q] <= RAM_W'(s_data);
    end
  end

endmodule

// File: rtl/adc_vip_top.sv
// Sawtooth ADC source -> FWFT FIFO -> VIP capture RAM.
// Ports: clk, rst_n, adc_en in; vip_full, FIFO flags/counts out.
module adc_vip_top
  import adc_vip_pkg::*;
#(
  parameter int PERIOD            = 12,
  parameter int SAMP              = 256,
  parameter int TDATA_WIDTH       = TDATA_W,
  parameter int FIFO_DEPTH        = FIFO_D,
  parameter int PROG_EMPTY_THRESH = 16,
  parameter int PROG_FULL_THRESH  = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic adc_en,
  output logic vip_full,
  output logic almost_empty_axis,
  output logic almost_full_axis,
  output logic prog_empty_axis,
  output logic prog_full_axis,
  output logic [$clog2(FIFO_DEPTH)-1:0] rd_data_count_axis,
  output logic [$clog2(FIFO_DEPTH)-1:0] wr_data_count_axis
);

  localparam int AW = cnt_w(FIFO_DEPTH);
  localparam int PW = $clog2(PERIOD);
  localparam int DW = TDATA_WIDTH;

  localparam logic [AW:0] OCC_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] OCC_AF   = (AW+1)'(FIFO_DEPTH - 1);
  localparam logic [AW:0] OCC_AE   = (AW+1)'(1);
  localparam logic [AW:0] OCC_PE   = (AW+1)'(PROG_EMPTY_THRESH);
  localparam logic [AW:0] OCC_PF   = (AW+1)'(PROG_FULL_THRESH);
  localparam logic [PW-1:0] PH_LAST = PW'(PERIOD - 1);

  logic [DW-1:0] mem [FIFO_DEPTH];

  logic [PW-1:0] phase_q, phase_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   occ_q, occ_d;

  logic          ae_q, ae_d;
  logic          af_q, af_d;
  logic          pe_q, pe_d;
  logic          pf_q, pf_d;
  logic [AW-1:0] cnt_q, cnt_d;

  logic          full, empty;
  logic          push, pop;
  logic          cap_ready;
  logic [DW-1:0] src_word;

  assign full  = (occ_q == OCC_FULL);
  assign empty = (occ_q == '0);

  // Full FIFO stalls the source: sample and index are held.
  assign push = adc_en & ~full;
  assign pop  = ~empty & cap_ready;

  assign src_word = DW'(phase_q);

  always_comb begin
    phase_d = phase_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    occ_d   = occ_q;
    if (push) begin
      phase_d = (phase_q == PH_LAST) ? '0
                                     : phase_q + 1'b1;
      wptr_d  = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Flags track the occupancy this edge produces.
  always_comb begin
    ae_d  = (occ_d <= OCC_AE);
    af_d  = (occ_d >= OCC_AF);
    pe_d  = (occ_d <= OCC_PE);
    pf_d  = (occ_d >= OCC_PF);
    cnt_d = occ_d[AW] ? '1 : occ_d[AW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
      ae_q    <= 1'b1;
      af_q    <= 1'b0;
      pe_q    <= 1'b1;
      pf_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      occ_q   <= occ_d;
      ae_q    <= ae_d;
      af_q    <= af_d;
      pe_q    <= pe_d;
      pf_q    <= pf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= src_word;
    end
  end

  assign almost_empty_axis  = ae_q;
  assign almost_full_axis   = af_q;
  assign prog_empty_axis    = pe_q;
  assign prog_full_axis     = pf_q;
  assign rd_data_count_axis = cnt_q;
  assign wr_data_count_axis = cnt_q;

  adc_vip_capture #(
    .SAMP (SAMP),
    .DW   (DW)
  ) vip_inst (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (~empty),
    .s_data   (mem[rptr_q]),
    .s_ready  (cap_ready),
    .vip_full (vip_full)
  );

endmodule

// File: tb/tb_adc_vip_top.sv
// Self-checking bench for adc_vip_top.
// Queue-level reference model of source, FIFO and capture.
module tb_adc_vip_top;
  import adc_vip_pkg::*;

  localparam int PERIOD = 12;
  localparam int SAMP   = 256;
  localparam int DEPTH  = 32;
  localparam int PE_T   = 16;
  localparam int PF_T   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic adc_en = 1'b0;
  logic vip_full;
  logic ae, af, pe, pf;
  logic [CNT_W-1:0] rd_cnt, wr_cnt;

  adc_vip_top DUT (
    .clk                (clk),
    .rst_n              (rst_n),
    .adc_en             (adc_en),
    .vip_full           (vip_full),
    .almost_empty_axis  (ae),
    .almost_full_axis   (af),
    .prog_empty_axis    (pe),
    .prog_full_axis     (pf),
    .rd_data_count_axis (rd_cnt),
    .wr_data_count_axis (wr_cnt)
  );

  always #5 clk = ~clk;

  int applied = 0;
  int miscmp  = 0;

  int q[$];
  int m_n, m_ptr, edge_cnt;
  bit m_done;
  int ram_m [SAMP];

  logic [14:0] obs;
  assign obs = {vip_full, ae, af, pe, pf, rd_cnt, wr_cnt};

  function automatic logic [14:0] exp_flags(int o, bit d);
    logic [4:0] c;
    c = (o > 31) ? 5'd31 : 5'(o);
    return {d, o <= 1, o >= DEPTH - 1,
            o <= PE_T, o >= PF_T, c, c};
  endfunction

  task automatic model_reset();
    q.delete();
    m_n = 0;
    m_ptr = 0;
    m_done = 0;
    edge_cnt = 0;
  endtask

  // One clock edge; the model follows the spec's push/pop rules.
  task automatic tick(input bit en);
    bit do_pop, do_push;
    adc_en = en;
    @(posedge clk);
    do_pop  = (q.size() > 0) && !m_done;
    do_push = en && (q.size() < DEPTH);
    if (do_pop) begin
      ram_m[m_ptr] = q.pop_front();
      m_ptr++;
      if (m_ptr == SAMP) m_done = 1;
    end
    if (do_push) begin
      q.push_back(m_n % PERIOD);
      m_n++;
    end
    #1;
    edge_cnt++;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_ram(input string tag);
    logic [31:0] got;
    for (int i = 0; i < SAMP; i++) begin
      got = DUT.vip_inst.ram[i];
      applied++;
      if (got !== 32'(ram_m[i])) begin
        miscmp++;
        $display("FAIL %s ram[%0d]: got %0d want %0d",
                 tag, i, got, ram_m[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    adc_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    applied++;
    if (obs !== exp_flags(0, 0)) begin
      miscmp++;
      $display("FAIL reset_state: got %h want %h",
               obs, exp_flags(0, 0));
    end
  endtask

  // Runs until the model completes; returns DUT rise edge.
  task automatic run_capture(input string tag,
                             input int gs, input int glen,
                             input bit rnd,
                             output int rise);
    bit en;
    rise = -1;
    for (int k = 0; k < 3000; k++) begin
      if (rnd) en = ($urandom_range(0, 3) != 0);
      else en = !((edge_cnt + 1 >= gs) &&
                  (edge_cnt + 1 < gs + glen));
      tick(en);
      applied++;
      if (obs !== exp_flags(q.size(), m_done)) begin
        miscmp++;
        $display("FAIL %s flags@%0d: got %h want %h", tag,
                 edge_cnt, obs, exp_flags(q.size(), m_done));
      end
      if (vip_full === 1'b1 && rise < 0) rise = edge_cnt;
      if (m_done) break;
    end
    applied++;
    if (!m_done || rise < 0) begin
      miscmp++;
      $display("FAIL %s timeout: got rise %0d want done",
               tag, rise);
    end
  endtask

  task automatic test_basic_capture();
    int rise;
    logic [31:0] r11, r12, r255;
    release_reset();
    run_capture("basic", 0, 0, 0, rise);
    applied++;
    if (rise != SAMP + 1) begin
      miscmp++;
      $display("FAIL basic_rise: got %0d want %0d",
               rise, SAMP + 1);
    end
    check_ram("basic");
    r11  = DUT.vip_inst.ram[11];
    r12  = DUT.vip_inst.ram[12];
    r255 = DUT.vip_inst.ram[255];
    applied++;
    if (r11 !== 32'd11 || r12 !== 32'd0 || r255 !== 32'd3) begin
      miscmp++;
      $display("FAIL basic_spot: got %0d/%0d/%0d want 11/0/3",
               r11, r12, r255);
    end
  endtask

  task automatic test_fill_after_done();
    int pf_edge = -1;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      applied++;
      if (obs !== exp_flags(q.size(), m_done)) begin
        miscmp++;
        $display("FAIL fill flags@%0d: got %h want %h",
                 edge_cnt, obs, exp_flags(q.size(), m_done));
      end
      if (q.size() == PF_T - 1) begin
        applied++;
        if (pf !== 1'b0) begin
          miscmp++;
          $display("FAIL prog_full_at_15: got %b want 0", pf);
        end
      end
      if (pf === 1'b1 && pf_edge < 0) pf_edge = edge_cnt;
    end
    applied++;
    if (pf_edge != SAMP + 1 + PF_T - 1) begin
      miscmp++;
      $display("FAIL prog_full_edge: got %0d want %0d",
               pf_edge, SAMP + PF_T);
    end
    applied++;
    if (rd_cnt !== 5'd31 || wr_cnt !== 5'd31 ||
        af !== 1'b1 || pf !== 1'b1) begin
      miscmp++;
      $display("FAIL fill_sat: got %0d/%0d af%b pf%b want 31/31 1 1",
               rd_cnt, wr_cnt, af, pf);
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    applied++;
    if (obs !== exp_flags(0, 0)) begin
      miscmp++;
      $display("FAIL async_reset: got %h want %h",
               obs, exp_flags(0, 0));
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_gap();
    int rise;
    int gs;
    logic [31:0] r0;
    gs = int'($urandom_range(20, 200));
    release_reset();
    tick(1);
    tick(1);
    r0 = DUT.vip_inst.ram[0];
    applied++;
    if (r0 !== 32'd0) begin
      miscmp++;
      $display("FAIL reset_ram0: got %0d want 0", r0);
    end
    run_capture("gap", gs, 10, 0, rise);
    applied++;
    if (rise != SAMP + 1 + 10) begin
      miscmp++;
      $display("FAIL gap_rise: got %0d want %0d",
               rise, SAMP + 11);
    end
    check_ram("gap");
  endtask

  task automatic test_random_en();
    int rise;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
    run_capture("rand", 0, 0, 1, rise);
    for (int k = 0; k < 20; k++) begin
      tick(($urandom_range(0, 1) != 0));
      applied++;
      if (obs !== exp_flags(q.size(), m_done)) begin
        miscmp++;
        $display("FAIL rand_tail flags: got %h want %h",
                 obs, exp_flags(q.size(), m_done));
      end
    end
    check_ram("rand");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_capture();
    test_fill_after_done();
    test_async_reset();
    test_gap();
    test_random_en();
    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscmp);
    $finish;
  end

endmodule
